trit_stream_decoder: RTL and testbench

//  Receive side of the 2-bit ternary trit encoding used by the ternary gate library
//  (00=0, 01=1, 10=2, 11=illegal). Accepts a serial, MSB-first stream of N_TRITS trits

---
 rtl/trit_stream_decoder.sv | 100 ++++++++++
 tb/tb_trit_stream_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/trit_stream_decoder.sv
// Serial MSB-first 2-bit trit stream to unsigned binary word converter.
// Optional illegal-code counter on err_cnt when TRIT_ERR_CNT_EN is defined.
module trit_stream_decoder #(
  parameter int N_TRITS = 6,
  parameter int BIN_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       trit_in,
  input  logic             trit_valid,
  output logic             trit_ready,
  output logic [BIN_W-1:0] bin_out,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic             word_err,
  output logic [7:0]       err_cnt
);

  localparam int CW = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_TRITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             flag;

  logic             bad;
  logic [1:0]       digit;
  logic [BIN_W-1:0] acc_nx;
  logic             flag_nx;
  logic             xfer;

  assign trit_ready = (state == COLLECT);
  assign bin_valid  = (state == HOLD);

  assign bad     = (trit_in == 2'b11);
  assign digit   = bad ? 2'd0 : trit_in;
  assign acc_nx  = (acc << 1) + acc + BIN_W'(digit);
  assign flag_nx = flag | bad;
  assign xfer    = trit_valid & trit_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      acc      <= '0;
      cnt      <= '0;
      flag     <= 1'b0;
      bin_out  <= '0;
      word_err <= 1'b0;
    end else if (flush) begin
      state <= COLLECT;
      acc   <= '0;
      cnt   <= '0;
      flag  <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (xfer) begin
            if (cnt == LAST) begin
              bin_out  <= acc_nx;
              word_err <= flag_nx;
              state    <= HOLD;
            end else begin
              acc  <= acc_nx;
              cnt  <= cnt + 1'b1;
              flag <= flag_nx;
            end
          end
        end
        HOLD: begin
          if (bin_ready) begin
            state <= COLLECT;
            acc   <= '0;
            cnt   <= '0;
            flag  <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef TRIT_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= 8'h00;
    else if (xfer && bad && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'h01;
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_trit_stream_decoder.sv
// Directed self-checking bench for trit_stream_decoder.
// Inputs change #1 after rising edges; outputs are sampled at the same point.
module tb_trit_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] trit_in;
  logic       trit_valid;
  logic       trit_ready;
  logic [9:0] bin_out;
  logic       bin_valid;
  logic       bin_ready;
  logic       word_err;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef TRIT_ERR_CNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  trit_stream_decoder #(.N_TRITS(6), .BIN_W(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .trit_in(trit_in),
    .trit_valid(trit_valid),
    .trit_ready(trit_ready),
    .bin_out(bin_out),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .word_err(word_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] code);
    trit_valid = 1'b1;
    trit_in    = code;
    tick();
    trit_valid = 1'b0;
  endtask

  // six trits, first element is the most significant
  task automatic word(input logic [1:0] c0, input logic [1:0] c1,
                      input logic [1:0] c2, input logic [1:0] c3,
                      input logic [1:0] c4, input logic [1:0] c5);
    push(c0); push(c1); push(c2); push(c3); push(c4); push(c5);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    trit_in    = 2'b00;
    trit_valid = 1'b0;
    bin_ready  = 1'b1;
    #12;
    chk("rst_bin_out", 32'(bin_out), 0);
    chk("rst_bin_valid", 32'(bin_valid), 0);
    chk("rst_word_err", 32'(word_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(trit_ready), 1);

    // word 0,0,0,1,2,1 = 16
    push(0); push(0); push(0); push(1); push(2);
    chk("t1_no_early_valid", 32'(bin_valid), 0);
    push(1);
    chk("t1_valid", 32'(bin_valid), 1);
    chk("t1_bin_out", 32'(bin_out), 16);
    chk("t1_word_err", 32'(word_err), 0);
    chk("t1_ready_low", 32'(trit_ready), 0);
    tick();
    chk("t1_valid_1cyc", 32'(bin_valid), 0);
    chk("t1_ready_back", 32'(trit_ready), 1);

    // all twos then all zeros
    word(2, 2, 2, 2, 2, 2);
    chk("t2_max", 32'(bin_out), 728);
    tick();
    word(0, 0, 0, 0, 0, 0);
    chk("t2_zero", 32'(bin_out), 0);
    chk("t2_zero_valid", 32'(bin_valid), 1);
    tick();

    // illegal code in second position
    word(1, 3, 0, 0, 0, 2);
    chk("t3_bin_out", 32'(bin_out), 245);
    chk("t3_word_err", 32'(word_err), 1);
    chk("t3_err_cnt", 32'(err_cnt), 32'(ERR_EN));
    tick();
    word(0, 0, 0, 0, 0, 1);
    chk("t3_clean_out", 32'(bin_out), 1);
    chk("t3_clean_err", 32'(word_err), 0);
    tick();

    // back-pressure: 0,0,1,0,0,0 = 27 held, then 2,0,0,0,0,0 = 486
    bin_ready = 1'b0;
    word(0, 0, 1, 0, 0, 0);
    trit_valid = 1'b1;
    trit_in    = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_ready", 32'(trit_ready), 0);
      chk("t4_hold_valid", 32'(bin_valid), 1);
      chk("t4_hold_out", 32'(bin_out), 27);
      tick();
    end
    bin_ready = 1'b1;
    tick();
    chk("t4_release_valid", 32'(bin_valid), 0);
    chk("t4_release_ready", 32'(trit_ready), 1);
    tick();
    trit_valid = 1'b0;
    push(0); push(0); push(0); push(0);
    chk("t4_not_done", 32'(bin_valid), 0);
    push(0);
    chk("t4_bin_out", 32'(bin_out), 486);
    tick();

    // flush after 3 trits, then flush alongside an illegal trit
    push(1); push(1); push(1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    flush = 1'b1;
    push(3);
    flush = 1'b0;
    word(0, 0, 0, 0, 0, 1);
    chk("t5_bin_out", 32'(bin_out), 1);
    chk("t5_word_err", 32'(word_err), 0);
    chk("t5_err_cnt", 32'(err_cnt), 32'(ERR_EN));
    tick();

    // flush while holding: valid drops, value kept
    bin_ready = 1'b0;
    word(0, 0, 0, 0, 1, 1);
    chk("t5h_out", 32'(bin_out), 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5h_valid", 32'(bin_valid), 0);
    chk("t5h_keep", 32'(bin_out), 4);
    chk("t5h_ready", 32'(trit_ready), 1);
    bin_ready = 1'b1;

    // reset mid-word, then reset while holding
    push(2); push(2); push(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6a_out", 32'(bin_out), 0);
    chk("t6a_valid", 32'(bin_valid), 0);
    chk("t6a_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick();
    bin_ready = 1'b0;
    word(3, 0, 0, 0, 0, 2);
    chk("t6b_pre_out", 32'(bin_out), 2);
    chk("t6b_pre_err", 32'(word_err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b_out", 32'(bin_out), 0);
    chk("t6b_valid", 32'(bin_valid), 0);
    chk("t6b_word_err", 32'(word_err), 0);
    chk("t6b_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    bin_ready = 1'b1;
    tick();
    word(0, 0, 0, 1, 2, 1);
    chk("t6_after_out", 32'(bin_out), 16);
    chk("t6_after_valid", 32'(bin_valid), 1);
    tick();
    chk("t6_after_drop", 32'(bin_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
